// File: rtl/planificador_ascensor.sv
// planificador_ascensor: SCAN request scheduler for the 4-floor elevator.
// Optional ASCENSOR_EMERGENCIA_EN adds the emergencia recall-to-floor-1 input.
module planificador_ascensor #(
  parameter int DOOR_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       boton_valid,
  input  logic [3:0] boton_pres,
  input  logic [1:0] piso,
  input  logic       puertas,
`ifdef ASCENSOR_EMERGENCIA_EN
  input  logic       emergencia,
`endif
  output logic [3:0] memoria,
  output logic [1:0] direccion,
  output logic [9:0] pendientes,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_MOVE,
    S_DWELL
  } state_t;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_UP   = 2'd1;
  localparam logic [1:0] D_DN   = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

  state_t           r_state, w_state_n;
  logic [3:0]       r_mem, w_mem_n;
  logic [1:0]       r_dir, w_dir_n;
  logic [1:0]       r_tgt, w_tgt_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [9:0]       r_pend, w_set, w_clr;
`ifdef ASCENSOR_EMERGENCIA_EN
  logic             r_emg;
`endif

  logic [3:0] w_cab, w_uph, w_dnh, w_req;
  logic [3:0] w_stop, w_rt_m;
  logic       w_above, w_below, w_here, w_ahead_t;
  logic [1:0] w_nup, w_ndn, w_dup, w_ddn;
  logic [1:0] w_t, w_d, w_rt_t;
  logic [9:0] w_cm, w_um, w_dm;
  logic [3:0] w_ub, w_db;

  function automatic logic [3:0] f_above(input logic [1:0] p);
    f_above = 4'b1110 << p;
  endfunction

  function automatic logic [3:0] f_below(input logic [1:0] p);
    f_below = (4'b0001 << p) - 4'd1;
  endfunction

  function automatic logic [1:0] f_low(input logic [3:0] m);
    f_low = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) f_low = 2'(i);
  endfunction

  function automatic logic [1:0] f_high(input logic [3:0] m);
    f_high = 2'd0;
    for (int i = 0; i < 4; i++)
      if (m[i]) f_high = 2'(i);
  endfunction

  // Cabin code wins; otherwise the hall call matching the travel direction.
  function automatic logic [3:0] f_code(
    input logic [1:0] t,
    input logic [1:0] d,
    input logic [3:0] cab,
    input logic [3:0] up,
    input logic [3:0] dn
  );
    logic [3:0] c_up, c_dn;
    c_up = 4'd5 + {1'b0, t, 1'b0};
    c_dn = 4'd4 + {1'b0, t, 1'b0};
    if (cab[t])          f_code = {2'b00, t} + 4'd1;
    else if (d == D_DN)  f_code = dn[t] ? c_dn : c_up;
    else                 f_code = up[t] ? c_up : c_dn;
  endfunction

  assign w_cab   = r_pend[3:0];
  assign w_uph   = {1'b0, r_pend[8], r_pend[6], r_pend[4]};
  assign w_dnh   = {r_pend[9], r_pend[7], r_pend[5], 1'b0};
  assign w_req   = w_cab | w_uph | w_dnh;
  assign w_above = |(w_req & f_above(piso));
  assign w_below = |(w_req & f_below(piso));
  assign w_nup   = f_low(w_req & f_above(piso));
  assign w_ndn   = f_high(w_req & f_below(piso));
  assign w_dup   = w_nup - piso;
  assign w_ddn   = piso - w_ndn;
  assign w_stop  = w_cab | ((r_dir == D_DN) ? w_dnh : w_uph);

  always_comb begin
    w_set = '0;
    if (boton_valid && boton_pres >= 4'd1 && boton_pres <= 4'd10)
      w_set = 10'd1 << (boton_pres - 4'd1);
  end

  // Target selection for SELECT
  always_comb begin
    w_t    = piso;
    w_d    = r_dir;
    w_here = w_req[piso];
    if (r_dir == D_UP)
      w_here = w_cab[piso] | w_uph[piso] | (w_dnh[piso] & ~w_above);
    else if (r_dir == D_DN)
      w_here = w_cab[piso] | w_dnh[piso] | (w_uph[piso] & ~w_below);
    if (!w_here) begin
      if (r_dir == D_UP && w_above) begin
        w_t = w_nup;
      end else if (r_dir == D_DN && w_below) begin
        w_t = w_ndn;
      end else if (r_dir == D_UP) begin
        w_t = w_ndn;
        w_d = D_DN;
      end else if (r_dir == D_DN) begin
        w_t = w_nup;
        w_d = D_UP;
      end else if (w_below && (!w_above || w_ddn <= w_dup)) begin
        w_t = w_ndn;
        w_d = D_DN;
      end else begin
        w_t = w_nup;
        w_d = D_UP;
      end
    end
  end

  // Stops strictly between the car and its target, in travel direction
  always_comb begin
    w_rt_m = '0;
    w_rt_t = r_tgt;
    if (r_dir == D_UP) begin
      w_rt_m = w_stop & f_above(piso) & f_below(r_tgt);
      w_rt_t = f_low(w_rt_m);
    end else if (r_dir == D_DN) begin
      w_rt_m = w_stop & f_below(piso) & f_above(r_tgt);
      w_rt_t = f_high(w_rt_m);
    end
  end

  always_comb begin
    w_ahead_t = 1'b0;
    if (r_dir == D_UP)      w_ahead_t = |(w_req & f_above(r_tgt));
    else if (r_dir == D_DN) w_ahead_t = |(w_req & f_below(r_tgt));
    w_ub = {1'b0, r_tgt, 1'b0} + 4'd4;
    w_db = {1'b0, r_tgt, 1'b0} + 4'd3;
    w_cm = 10'd1 << r_tgt;
    w_um = (r_tgt != 2'd3) ? (10'd1 << w_ub) : '0;
    w_dm = (r_tgt != 2'd0) ? (10'd1 << w_db) : '0;
  end

  always_comb begin
    w_state_n = r_state;
    w_mem_n   = r_mem;
    w_dir_n   = r_dir;
    w_tgt_n   = r_tgt;
    w_cnt_n   = r_cnt;
    w_clr     = '0;
    if (en) begin
      unique case (r_state)
        S_IDLE: begin
          w_mem_n = '0;
          w_dir_n = D_IDLE;
          if (|r_pend) w_state_n = S_SELECT;
        end
        S_SELECT: begin
          if (|r_pend) begin
            w_tgt_n   = w_t;
            w_dir_n   = w_d;
            w_mem_n   = f_code(w_t, w_d, w_cab, w_uph, w_dnh);
            w_state_n = S_MOVE;
          end else begin
            w_mem_n   = '0;
            w_dir_n   = D_IDLE;
            w_state_n = S_IDLE;
          end
        end
        S_MOVE: begin
          if (piso == r_tgt && puertas) begin
            w_state_n = S_DWELL;
            w_cnt_n   = CNT_LOAD;
          end else if (|w_rt_m) begin
            w_tgt_n = w_rt_t;
            w_mem_n = f_code(w_rt_t, r_dir, w_cab, w_uph, w_dnh);
          end
        end
        S_DWELL: begin
          if (r_cnt == '0) begin
            w_clr = w_cm
                  | ((r_dir != D_DN || !w_ahead_t) ? w_um : '0)
                  | ((r_dir != D_UP || !w_ahead_t) ? w_dm : '0);
            w_mem_n   = '0;
            w_state_n = S_SELECT;
          end else begin
            w_cnt_n = r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mem   <= '0;
      r_dir   <= D_IDLE;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
`ifdef ASCENSOR_EMERGENCIA_EN
      r_emg   <= 1'b0;
    end else if (emergencia) begin
      r_state <= S_MOVE;
      r_mem   <= 4'd1;
      r_dir   <= (piso != 2'd0) ? D_DN : D_IDLE;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_emg   <= 1'b1;
    end else if (r_emg) begin
      r_state <= S_IDLE;
      r_mem   <= '0;
      r_dir   <= D_IDLE;
      r_pend  <= w_set;
      r_emg   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_mem   <= w_mem_n;
      r_dir   <= w_dir_n;
      r_tgt   <= w_tgt_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= (r_pend | w_set) & ~w_clr;
    end
  end

  assign memoria    = r_mem;
  assign direccion  = r_dir;
  assign pendientes = r_pend;
  assign ocupado    = (r_state != S_IDLE);

endmodule

// File: tb/tb_planificador_ascensor.sv
// Directed bench for planificador_ascensor: SCAN order, retarget, dwell,
// ignored codes, en freeze, async reset and (if enabled) emergency recall.
module tb_planificador_ascensor;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       boton_valid = 1'b0;
  logic [3:0] boton_pres = 4'd0;
  logic [1:0] piso = 2'd0;
  logic       puertas = 1'b0;
`ifdef ASCENSOR_EMERGENCIA_EN
  logic       emergencia = 1'b0;
`endif
  logic [3:0] memoria;
  logic [1:0] direccion;
  logic [9:0] pendientes;
  logic       ocupado;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  planificador_ascensor #(.DOOR_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .boton_valid(boton_valid),
    .boton_pres(boton_pres),
    .piso(piso),
    .puertas(puertas),
`ifdef ASCENSOR_EMERGENCIA_EN
    .emergencia(emergencia),
`endif
    .memoria(memoria),
    .direccion(direccion),
    .pendientes(pendientes),
    .ocupado(ocupado)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] c);
    boton_valid = 1'b1;
    boton_pres  = c;
    tick();
    boton_valid = 1'b0;
    boton_pres  = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    total++; if (memoria !== 4'd0) begin bad++; $display("FAIL rst_mem got %0d want 0", memoria); end
    total++; if (direccion !== 2'd0) begin bad++; $display("FAIL rst_dir got %0d want 0", direccion); end
    total++; if (pendientes !== 10'h000) begin bad++; $display("FAIL rst_pend got %h want 000", pendientes); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_ocup got %b want 0", ocupado); end
    rst = 1'b0;
    tick(2);
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_idle got %b want 0", ocupado); end
  endtask

  task automatic test_ignore();
    press(4'd0);
    press(4'd11);
    press(4'd15);
    tick();
    total++; if (pendientes !== 10'h000) begin bad++; $display("FAIL ign_pend got %h want 000", pendientes); end
    total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL ign_ocup got %b want 0", ocupado); end
  endtask

  task automatic test_basic();
    piso = 2'd0;
    press(4'd3);
    total++; if (pendientes !== 10'h004) begin bad++; $display("FAIL b_latch got %h want 004", pendientes); end
    tick();
    total++; if (memoria !== 4'd0) begin bad++; $display("FAIL b_lat1 got %0d want 0", memoria); end
    tick();
    total++; if (memoria !== 4'd3) begin bad++; $display("FAIL b_lat2 got %0d want 3", memoria); end
    total++; if (direccion !== 2'd1) begin bad++; $display("FAIL b_dir got %0d want 1", direccion); end
    piso = 2'd2;
    tick();
    puertas = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (memoria !== 4'd3 || pendientes !== 10'h004) begin
        bad++; $display("FAIL b_hold%0d got %0d/%h want 3/004", i, memoria, pendientes);
      end
    end
    tick();
    total++; if (memoria !== 4'd0 || pendientes !== 10'h000) begin
      bad++; $display("FAIL b_clr got %0d/%h want 0/000", memoria, pendientes);
    end
    tick();
    total++; if (ocupado !== 1'b0 || direccion !== 2'd0) begin
      bad++; $display("FAIL b_idle got %b/%0d want 0/0", ocupado, direccion);
    end
    puertas = 1'b0;
  endtask

  task automatic test_retarget();
    piso = 2'd0;
    press(4'd4);
    tick(2);
    total++; if (memoria !== 4'd4) begin bad++; $display("FAIL rt_mem4 got %0d want 4", memoria); end
    piso = 2'd1;
    press(4'd9);
    tick();
    total++; if (memoria !== 4'd9) begin bad++; $display("FAIL rt_mem9 got %0d want 9", memoria); end
    total++; if (pendientes !== 10'h108) begin bad++; $display("FAIL rt_pend got %h want 108", pendientes); end
    piso = 2'd2;
    puertas = 1'b1;
    tick(5);
    total++; if (pendientes !== 10'h008 || memoria !== 4'd0) begin
      bad++; $display("FAIL rt_clr9 got %h/%0d want 008/0", pendientes, memoria);
    end
    puertas = 1'b0;
    tick();
    total++; if (memoria !== 4'd4 || direccion !== 2'd1) begin
      bad++; $display("FAIL rt_next got %0d/%0d want 4/1", memoria, direccion);
    end
    piso = 2'd3;
    puertas = 1'b1;
    tick(5);
    tick();
    total++; if (pendientes !== 10'h000 || ocupado !== 1'b0) begin
      bad++; $display("FAIL rt_done got %h/%b want 000/0", pendientes, ocupado);
    end
    puertas = 1'b0;
  endtask

  task automatic test_reverse();
    piso = 2'd0;
    press(4'd3);
    tick(2);
    piso = 2'd1;
    press(4'd1);
    press(4'd10);
    total++; if (pendientes !== 10'h205) begin bad++; $display("FAIL rv_pend got %h want 205", pendientes); end
    piso = 2'd2;
    puertas = 1'b1;
    tick(5);
    total++; if (pendientes !== 10'h201) begin bad++; $display("FAIL rv_clr3 got %h want 201", pendientes); end
    puertas = 1'b0;
    tick();
    total++; if (memoria !== 4'd10 || direccion !== 2'd1) begin
      bad++; $display("FAIL rv_up got %0d/%0d want 10/1", memoria, direccion);
    end
    piso = 2'd3;
    puertas = 1'b1;
    tick(5);
    total++; if (pendientes !== 10'h001) begin bad++; $display("FAIL rv_clr10 got %h want 001", pendientes); end
    puertas = 1'b0;
    tick();
    total++; if (memoria !== 4'd1 || direccion !== 2'd2) begin
      bad++; $display("FAIL rv_down got %0d/%0d want 1/2", memoria, direccion);
    end
    piso = 2'd0;
    puertas = 1'b1;
    tick(6);
    total++; if (pendientes !== 10'h000 || ocupado !== 1'b0) begin
      bad++; $display("FAIL rv_done got %h/%b want 000/0", pendientes, ocupado);
    end
    puertas = 1'b0;
  endtask

  task automatic test_dwell_press();
    piso = 2'd0;
    press(4'd2);
    tick(2);
    total++; if (memoria !== 4'd2) begin bad++; $display("FAIL dw_mem got %0d want 2", memoria); end
    piso = 2'd1;
    puertas = 1'b1;
    tick();
    press(4'd8);
    tick(2);
    press(4'd2);
    total++; if (pendientes !== 10'h080 || memoria !== 4'd0) begin
      bad++; $display("FAIL dw_clr got %h/%0d want 080/0", pendientes, memoria);
    end
    puertas = 1'b0;
    tick();
    total++; if (memoria !== 4'd8 || direccion !== 2'd1) begin
      bad++; $display("FAIL dw_next got %0d/%0d want 8/1", memoria, direccion);
    end
    piso = 2'd2;
    puertas = 1'b1;
    tick(5);
    total++; if (pendientes !== 10'h000) begin bad++; $display("FAIL dw_done got %h want 000", pendientes); end
    tick();
    puertas = 1'b0;
  endtask

  task automatic test_en_freeze();
    piso = 2'd0;
    en = 1'b0;
    press(4'd3);
    tick(2);
    total++; if (pendientes !== 10'h004 || ocupado !== 1'b0 || memoria !== 4'd0) begin
      bad++; $display("FAIL fz_idle got %h/%b/%0d want 004/0/0", pendientes, ocupado, memoria);
    end
    en = 1'b1;
    tick(2);
    total++; if (memoria !== 4'd3) begin bad++; $display("FAIL fz_mem got %0d want 3", memoria); end
    en = 1'b0;
    piso = 2'd2;
    puertas = 1'b1;
    tick(6);
    total++; if (memoria !== 4'd3 || pendientes !== 10'h004 || ocupado !== 1'b1) begin
      bad++; $display("FAIL fz_hold got %0d/%h/%b want 3/004/1", memoria, pendientes, ocupado);
    end
  endtask

  task automatic test_rst_mid();
    #2;
    rst = 1'b1;
    #1;
    total++; if (memoria !== 4'd0 || direccion !== 2'd0 || pendientes !== 10'h000 || ocupado !== 1'b0) begin
      bad++; $display("FAIL mid_rst got %0d/%0d/%h/%b want 0/0/000/0", memoria, direccion, pendientes, ocupado);
    end
    #1;
    rst = 1'b0;
    en = 1'b1;
    puertas = 1'b0;
    piso = 2'd0;
    tick(3);
    total++; if (ocupado !== 1'b0 || pendientes !== 10'h000) begin
      bad++; $display("FAIL mid_after got %b/%h want 0/000", ocupado, pendientes);
    end
  endtask

`ifdef ASCENSOR_EMERGENCIA_EN
  task automatic test_emergencia();
    piso = 2'd3;
    press(4'd1);
    emergencia = 1'b1;
    tick();
    total++; if (pendientes !== 10'h000 || memoria !== 4'd1 || direccion !== 2'd2) begin
      bad++; $display("FAIL em_on got %h/%0d/%0d want 000/1/2", pendientes, memoria, direccion);
    end
    press(4'd4);
    total++; if (pendientes !== 10'h000) begin bad++; $display("FAIL em_ign got %h want 000", pendientes); end
    piso = 2'd0;
    puertas = 1'b1;
    tick(3);
    total++; if (memoria !== 4'd1 || direccion !== 2'd0) begin
      bad++; $display("FAIL em_hold got %0d/%0d want 1/0", memoria, direccion);
    end
    emergencia = 1'b0;
    tick();
    total++; if (memoria !== 4'd0 || ocupado !== 1'b0) begin
      bad++; $display("FAIL em_off got %0d/%b want 0/0", memoria, ocupado);
    end
    puertas = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ignore();
    test_basic();
    test_retarget();
    test_reverse();
    test_dwell_press();
    test_en_freeze();
    test_rst_mid();
`ifdef ASCENSOR_EMERGENCIA_EN
    test_emergencia();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
